fpu_issue_ctrl: RTL
===================

Name: fpu_issue_ctrl

Overview:
- In-order issue/retire controller for the FPU functional units: adder, multiplier, divider/sqrt, and the min/max selector.
- Accepts one operation per cycle from the core over valid/ready, steers the handshake to the owning unit, and records the unit index in a tag FIFO.
- Retires results to the core strictly in issue order, regardless of unit latency.
- Sits between the FPU operand stage and the FPU writeback mux; operands and op are broadcast to all units in parallel.

Parameters:
- DEPTH, 4, tag FIFO entries = maximum in-flight ops (power of two, ≥2).
- N_UNITS, 4, number of attached functional units (fixed mapping from package).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- flush  in  1  pipeline flush; kills all in-flight ops
- valid_in  in  1  op valid from core
- ready_out  out  1  controller can accept op
- op  in  5  FPU_OP_* opcode
- unit_valid_out  out  N_UNITS  valid_in to each unit
- unit_ready_in  in  N_UNITS  ready_out from each unit
- unit_valid_in  in  N_UNITS  valid_out from each unit
- unit_ready_out  out  N_UNITS  ready_in to each unit
- unit_result  in  32*N_UNITS  float_out from each unit, unit i at [32i+31:32i]
- unit_flags  in  5*N_UNITS  {NV,DZ,OF,UF,NX} from each unit
- valid_out  out  1  retired result valid
- ready_in  in  1  writeback accepts result
- float_out  out  32  retired result
- fflags  out  5  flags of retired result
- fflags_acc  out  5  sticky OR of all retired flags
- fflags_clr  in  1  clear fflags_acc

Behaviour:
- Reset (sync, highest priority) empties the FIFO and clears fflags_acc. While reset is high: ready_out=0, all unit_valid_out=0, valid_out=0, float_out=0, fflags=0.
- Decode: fpu_unit_of(op) returns a unit index or UNIT_NONE. ADD/SUB→0, MUL→1, DIV/SQRT→2, MIN/MAX→3.
- Issue:
  - ready_out = !full && !flush && (unit==UNIT_NONE || unit_ready_in[unit]).
  - unit_valid_out[unit] = valid_in && !full && !flush; all other bits are 0.
  - The op is issued when valid_in && ready_out. The tag is pushed on the next clk edge.
  - No combinational path from ready_in to ready_out: a full FIFO blocks issue even in a retire cycle.
- Illegal op (UNIT_NONE): accepted and pushed as a null tag. At the head it retires with float_out=0, fflags=5'b10000.
- Retire:
  - Head tag h. valid_out = (h==UNIT_NONE || unit_valid_in[h]) && !empty && !flush.
  - float_out/fflags are the combinational mux of unit h outputs; 0 when valid_out=0.
  - unit_ready_out[h] = ready_in && !empty && !flush; all other bits are 0, so non-head units hold their results.
  - A retire (valid_out && ready_in) pops the head and ORs fflags into fflags_acc.
- Simultaneous push and pop: count is unchanged and pointers wrap modulo DEPTH. A pop on the last entry with a push in the same cycle is legal.
- Full: count==DEPTH. Empty: count==0.
- fflags_clr: fflags_acc becomes 0 next cycle. If a retire happens in the same cycle, the new flags win: fflags_acc <= retiring fflags.
- Flush: on the next edge, pointers and count go to 0; fflags_acc is kept.
  - In the flush cycle, no issue and no retire occur.
  - Units see the same flush and discard their own state.
- Latency: zero added cycles. Result visibility depends only on unit latency and head position.

Optional Feature:
- Macro FPU_ISSUE_PERF_CNT_EN.
- When defined, adds outputs perf_issued[31:0], perf_retired[31:0] and perf_stall[31:0].
  - perf_stall counts cycles with valid_in && !ready_out.
  - All three counters clear on reset, not on flush, and wrap at 2^32.
- When undefined, these ports and counters do not exist.

Decomposition:
- FPU_pkg gains:
  - localparams UNIT_ADD=0, UNIT_MUL=1, UNIT_DIV=2, UNIT_SEL=3, UNIT_NONE=N_UNITS.
  - A typedef for the tag width: $clog2(N_UNITS+1).
  - Function fpu_unit_of(op).
  - Flag bit positions FLAG_NV..FLAG_NX.
- One sub-module: fpu_tag_fifo (DEPTH × tag, sync reset, flush, push/pop, full/empty, head output).

Test Plan:
- Single MIN, with mocked selector latency 1 returning 32'h3f800000: unit_valid_out=4'b1000; next cycle valid_out=1, float_out=32'h3f800000, fflags=0; FIFO empty after retire.
- Out-of-order completion: issue DIV then ADD. ADD result 32'h40000000 is ready at cycle 2, DIV result 32'h3eaaaaab at cycle 10. valid_out stays 0 until cycle 10; DIV retires first, then ADD next cycle. unit_ready_out[0] stays 0 until DIV pops.
- Full: issue 4 MULs with the mul unit stalled. The 5th op sees ready_out=0 even with ready_in=1 on a retire cycle; it is accepted on the following cycle.
- Illegal op 5'h1f: accepted; retires with float_out=0, fflags=5'b10000; fflags_acc=5'b10000 until fflags_clr.
- Flush with 3 ops in flight and valid_out=1: valid_out drops in the flush cycle; next cycle empty=1 and ready_out=1. A subsequent ADD retires normally.
- Back-to-back ready_in=0 backpressure for 5 cycles on a SEL result: float_out is stable, unit_ready_out=0, and no pop occurs. When ready_in rises: one pop, and fflags_acc ORs in the NV flag from an sNaN operand.

Source files
------------

// File: rtl/fpu_issue_ctrl_pkg.sv
// Shared FPU issue definitions: unit indices, tag type, opcodes, flag bits
// and the op-to-unit decoder.
package fpu_issue_ctrl_pkg;

   localparam int NUM_UNITS = 4;
   localparam int TAG_W     = $clog2(NUM_UNITS + 1);

   typedef logic [TAG_W-1:0] tag_t;

   localparam tag_t UNIT_ADD  = tag_t'(0);
   localparam tag_t UNIT_MUL  = tag_t'(1);
   localparam tag_t UNIT_DIV  = tag_t'(2);
   localparam tag_t UNIT_SEL  = tag_t'(3);
   localparam tag_t UNIT_NONE = tag_t'(NUM_UNITS);

   localparam logic [4:0] FPU_OP_ADD  = 5'd0;
   localparam logic [4:0] FPU_OP_SUB  = 5'd1;
   localparam logic [4:0] FPU_OP_MUL  = 5'd2;
   localparam logic [4:0] FPU_OP_DIV  = 5'd3;
   localparam logic [4:0] FPU_OP_SQRT = 5'd4;
   localparam logic [4:0] FPU_OP_MIN  = 5'd5;
   localparam logic [4:0] FPU_OP_MAX  = 5'd6;

   localparam int FLAG_NV = 4;
   localparam int FLAG_DZ = 3;
   localparam int FLAG_OF = 2;
   localparam int FLAG_UF = 1;
   localparam int FLAG_NX = 0;

   localparam logic [4:0] FLAGS_ILLEGAL = 5'b00001 << FLAG_NV;

   function automatic tag_t fpu_unit_of(input logic [4:0] op);
      tag_t u;
      case (op)
         FPU_OP_ADD, FPU_OP_SUB:  u = UNIT_ADD;
         FPU_OP_MUL:              u = UNIT_MUL;
         FPU_OP_DIV, FPU_OP_SQRT: u = UNIT_DIV;
         FPU_OP_MIN, FPU_OP_MAX:  u = UNIT_SEL;
         default:                 u = UNIT_NONE;
      endcase
      return u;
   endfunction

endpackage

// File: rtl/fpu_tag_fifo.sv
// In-order tag FIFO holding the owning unit of every in-flight FPU op.
// Flush and reset both empty it; the storage itself is never cleared.
module fpu_tag_fifo
   import fpu_issue_ctrl_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic flush,
   input  logic push,
   input  tag_t push_tag,
   input  logic pop,
   output tag_t head,
   output logic full,
   output logic empty
);

   localparam int PW = $clog2(DEPTH);

   tag_t           mem [DEPTH];
   logic [PW-1:0]  wr_ptr;
   logic [PW-1:0]  rd_ptr;
   logic [PW:0]    count;

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + (PW+1)'(push) - (PW+1)'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_tag;
   end

   assign head  = mem[rd_ptr];
   assign full  = (count == (PW+1)'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/fpu_issue_ctrl.sv
// In-order issue/retire controller for the FPU units. Optional perf
// counters are enabled with FPU_ISSUE_PERF_CNT_EN.
module fpu_issue_ctrl
   import fpu_issue_ctrl_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int N_UNITS = NUM_UNITS
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 flush,
   input  logic                 valid_in,
   output logic                 ready_out,
   input  logic [4:0]           op,
   output logic [N_UNITS-1:0]   unit_valid_out,
   input  logic [N_UNITS-1:0]   unit_ready_in,
   input  logic [N_UNITS-1:0]   unit_valid_in,
   output logic [N_UNITS-1:0]   unit_ready_out,
   input  logic [32*N_UNITS-1:0] unit_result,
   input  logic [5*N_UNITS-1:0] unit_flags,
   output logic                 valid_out,
   input  logic                 ready_in,
   output logic [31:0]          float_out,
   output logic [4:0]           fflags,
   output logic [4:0]           fflags_acc,
   input  logic                 fflags_clr
`ifdef FPU_ISSUE_PERF_CNT_EN
   ,
   output logic [31:0]          perf_issued,
   output logic [31:0]          perf_retired,
   output logic [31:0]          perf_stall
`endif
);

   tag_t        unit;
   tag_t        head;
   logic        full;
   logic        empty;
   logic        unit_rdy;
   logic        head_vld;
   logic [31:0] head_res;
   logic [4:0]  head_fl;
   logic        issue_ok;
   logic        ret_ok;
   logic        push;
   logic        pop;

   // Null tags never wait on a unit and retire as an invalid-op result.
   always_comb begin
      unit     = fpu_unit_of(op);
      unit_rdy = (unit == UNIT_NONE);
      head_vld = (head == UNIT_NONE);
      head_res = '0;
      head_fl  = FLAGS_ILLEGAL;
      for (int i = 0; i < N_UNITS; i++) begin
         if (unit == tag_t'(i)) unit_rdy = unit_ready_in[i];
         if (head == tag_t'(i)) begin
            head_vld = unit_valid_in[i];
            head_res = unit_result[32*i +: 32];
            head_fl  = unit_flags[5*i +: 5];
         end
      end
   end

   always_comb begin
      issue_ok       = !reset && !full && !flush;
      ret_ok         = !reset && !empty && !flush;
      ready_out      = issue_ok && unit_rdy;
      valid_out      = ret_ok && head_vld;
      float_out      = valid_out ? head_res : '0;
      fflags         = valid_out ? head_fl : '0;
      unit_valid_out = '0;
      unit_ready_out = '0;
      for (int i = 0; i < N_UNITS; i++) begin
         unit_valid_out[i] = valid_in && issue_ok && (unit == tag_t'(i));
         unit_ready_out[i] = ready_in && ret_ok && (head == tag_t'(i));
      end
      push = valid_in && ready_out;
      pop  = valid_out && ready_in;
   end

   fpu_tag_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .push     (push),
      .push_tag (unit),
      .pop      (pop),
      .head     (head),
      .full     (full),
      .empty    (empty)
   );

   always_ff @(posedge clk) begin
      if (reset)
         fflags_acc <= '0;
      else if (pop)
         fflags_acc <= fflags_clr ? fflags : (fflags_acc | fflags);
      else if (fflags_clr)
         fflags_acc <= '0;
   end

`ifdef FPU_ISSUE_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_issued  <= '0;
         perf_retired <= '0;
         perf_stall   <= '0;
      end else begin
         if (push) perf_issued <= perf_issued + 32'd1;
         if (pop)  perf_retired <= perf_retired + 32'd1;
         if (valid_in && !ready_out) perf_stall <= perf_stall + 32'd1;
      end
   end
`endif

endmodule
